// File: rtl/ir_rx_nec_if.sv
// Decoded-output bundle of the NEC IR receiver.
// master = receiver side (drives), slave = display path (consumes).
interface ir_rx_nec_if #(
  parameter int NBITS = 32
);
  logic [NBITS-1:0] o_data;
  logic [7:0]       o_addr;
  logic [7:0]       o_cmd;
  logic             o_valid;
  logic             o_repeat;
  logic             o_err;
  logic [2:0]       o_err_code;
  logic             o_busy;

  modport master (output o_data, o_addr, o_cmd, o_valid, o_repeat, o_err, o_err_code, o_busy);
  modport slave  (input  o_data, o_addr, o_cmd, o_valid, o_repeat, o_err, o_err_code, o_busy);
endinterface

// File: rtl/ir_rx_nec.sv
// NEC IR receiver: tick-based pulse-width classification, repeat codes,
// inversion checks, timeouts and error reporting on a single clock.
module ir_rx_nec #(
  parameter int CLK_DIV     = 50,
  parameter int CNT_W       = 16,
  parameter int NBITS       = 32,
  parameter int INVERT_IN   = 1,
  parameter int CHECK_MODE  = 1,
  parameter int LEAD_MK_MIN = 8000,
  parameter int LEAD_MK_MAX = 10000,
  parameter int LEAD_SP_MIN = 4000,
  parameter int LEAD_SP_MAX = 5000,
  parameter int REP_SP_MIN  = 1800,
  parameter int REP_SP_MAX  = 2700,
  parameter int BIT_MK_MIN  = 300,
  parameter int BIT_MK_MAX  = 800,
  parameter int ZERO_SP_MIN = 300,
  parameter int ZERO_SP_MAX = 800,
  parameter int ONE_SP_MIN  = 1300,
  parameter int ONE_SP_MAX  = 2000,
  parameter int SPACE_TO    = 12000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_ir_rxb,
  ir_rx_nec_if.master    rx
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BC_W  = $clog2(NBITS + 1);
  localparam logic INV = (INVERT_IN != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, REP_MARK} state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [DIV_W-1:0] div_q;
  logic             lvl_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BC_W-1:0]  bcnt_q;
  logic [NBITS-1:0] sr_q, data_q;
  logic             have_q, valid_q, rep_q, err_q;
  logic [2:0]       code_q;

  function automatic logic in_win(input logic [CNT_W-1:0] w, input int lo, input int hi);
    return (int'(w) >= lo) && (int'(w) <= hi);
  endfunction

  logic tick, lvl, lvl_chg, sp_to, mk_to, check_ok;
  assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
  assign lvl     = sync_q[1] ^ INV;
  assign lvl_chg = (lvl != lvl_q);
  assign sp_to   = int'(cnt_q) >= SPACE_TO;
  assign mk_to   = int'(cnt_q) > LEAD_MK_MAX;

  generate
    if (NBITS == 32) begin : g_nec32
      assign check_ok = ((CHECK_MODE < 1) || (sr_q[31:24] == ~sr_q[23:16])) &&
                        ((CHECK_MODE < 2) || (sr_q[15:8]  == ~sr_q[7:0]));
      assign rx.o_addr = data_q[7:0];
      assign rx.o_cmd  = data_q[23:16];
    end else begin : g_nbits
      assign check_ok  = 1'b1;
      assign rx.o_addr = '0;
      assign rx.o_cmd  = '0;
    end
  endgenerate

  // In mark states any level change is a mark end; in space states a mark start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= {2{INV}};
      div_q   <= '0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      have_q  <= 1'b0;
      valid_q <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= {sync_q[0], i_ir_rxb};
      div_q   <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        lvl_q <= lvl;
        cnt_q <= lvl_chg ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        case (state_q)
          IDLE: if (lvl_chg && lvl) state_q <= LEAD_MARK;
          LEAD_MARK:
            if (lvl_chg) begin
              if (in_win(cnt_q, LEAD_MK_MIN, LEAD_MK_MAX)) state_q <= LEAD_SPACE;
              else begin err_q <= 1'b1; code_q <= 3'd1; state_q <= IDLE; end
            end else if (mk_to) begin err_q <= 1'b1; code_q <= 3'd5; state_q <= IDLE; end
          LEAD_SPACE:
            if (lvl_chg) begin
              if (in_win(cnt_q, LEAD_SP_MIN, LEAD_SP_MAX)) begin
                bcnt_q  <= '0;
                state_q <= BIT_MARK;
              end else if (in_win(cnt_q, REP_SP_MIN, REP_SP_MAX)) state_q <= REP_MARK;
              else begin err_q <= 1'b1; code_q <= 3'd2; state_q <= IDLE; end
            end else if (sp_to) begin err_q <= 1'b1; code_q <= 3'd5; state_q <= IDLE; end
          BIT_MARK:
            if (lvl_chg) begin
              if (!in_win(cnt_q, BIT_MK_MIN, BIT_MK_MAX)) begin
                err_q <= 1'b1; code_q <= 3'd3; state_q <= IDLE;
              end else if (bcnt_q == BC_W'(NBITS)) begin
                state_q <= IDLE;
                if (check_ok) begin
                  data_q  <= sr_q;
                  valid_q <= 1'b1;
                  have_q  <= 1'b1;
                end else begin err_q <= 1'b1; code_q <= 3'd6; end
              end else state_q <= BIT_SPACE;
            end else if (mk_to) begin err_q <= 1'b1; code_q <= 3'd5; state_q <= IDLE; end
          BIT_SPACE:
            if (lvl_chg) begin
              if (in_win(cnt_q, ZERO_SP_MIN, ZERO_SP_MAX) || in_win(cnt_q, ONE_SP_MIN, ONE_SP_MAX)) begin
                sr_q    <= {in_win(cnt_q, ONE_SP_MIN, ONE_SP_MAX), sr_q[NBITS-1:1]};
                bcnt_q  <= bcnt_q + 1'b1;
                state_q <= BIT_MARK;
              end else begin err_q <= 1'b1; code_q <= 3'd4; state_q <= IDLE; end
            end else if (sp_to) begin err_q <= 1'b1; code_q <= 3'd5; state_q <= IDLE; end
          REP_MARK:
            if (lvl_chg) begin
              state_q <= IDLE;
              if (!in_win(cnt_q, BIT_MK_MIN, BIT_MK_MAX)) begin err_q <= 1'b1; code_q <= 3'd3; end
              else if (have_q) rep_q <= 1'b1;
              else begin err_q <= 1'b1; code_q <= 3'd7; end
            end else if (mk_to) begin err_q <= 1'b1; code_q <= 3'd5; state_q <= IDLE; end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx.o_data     = data_q;
  assign rx.o_valid    = valid_q;
  assign rx.o_repeat   = rep_q;
  assign rx.o_err      = err_q;
  assign rx.o_err_code = code_q;
  assign rx.o_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_ir_rx_nec.sv
// Directed bench for ir_rx_nec with timing windows scaled down 20x and one tick per clk.
module tb_ir_rx_nec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxb = 1'b1;
  always #5 clk = ~clk;

  ir_rx_nec_if #(.NBITS(32)) b0 ();
  ir_rx_nec_if #(.NBITS(32)) b1 ();

  ir_rx_nec #(
    .CLK_DIV(1), .CNT_W(16), .NBITS(32), .INVERT_IN(1), .CHECK_MODE(1),
    .LEAD_MK_MIN(400), .LEAD_MK_MAX(500), .LEAD_SP_MIN(200), .LEAD_SP_MAX(250),
    .REP_SP_MIN(90), .REP_SP_MAX(135), .BIT_MK_MIN(15), .BIT_MK_MAX(40),
    .ZERO_SP_MIN(15), .ZERO_SP_MAX(40), .ONE_SP_MIN(65), .ONE_SP_MAX(100), .SPACE_TO(600)
  ) u_dut0 (.clk(clk), .rst(rst), .i_ir_rxb(rxb), .rx(b0.master));

  // Same timing, no inversion check.
  ir_rx_nec #(
    .CLK_DIV(1), .CNT_W(16), .NBITS(32), .INVERT_IN(1), .CHECK_MODE(0),
    .LEAD_MK_MIN(400), .LEAD_MK_MAX(500), .LEAD_SP_MIN(200), .LEAD_SP_MAX(250),
    .REP_SP_MIN(90), .REP_SP_MAX(135), .BIT_MK_MIN(15), .BIT_MK_MAX(40),
    .ZERO_SP_MIN(15), .ZERO_SP_MAX(40), .ONE_SP_MIN(65), .ONE_SP_MAX(100), .SPACE_TO(600)
  ) u_dut1 (.clk(clk), .rst(rst), .i_ir_rxb(rxb), .rx(b1.master));

  int checks = 0;
  int errors = 0;
  int nv0 = 0, nr0 = 0, ne0 = 0, nv1 = 0, nmulti = 0;

  always @(negedge clk) begin
    if (b0.o_valid)  nv0++;
    if (b0.o_repeat) nr0++;
    if (b0.o_err)    ne0++;
    if (b1.o_valid)  nv1++;
    if (int'(b0.o_valid) + int'(b0.o_repeat) + int'(b0.o_err) > 1) nmulti++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic lv(input logic v, input int n);
    rxb = v;
    repeat (n) @(negedge clk);
  endtask

  // Active-low pin: 0 = mark. Nominal (scaled) widths: 450/225 leader, 28 mark, 28/84 space.
  task automatic send(input logic [31:0] w, input int nb, input bit stop);
    lv(1'b0, 450);
    lv(1'b1, 225);
    for (int i = 0; i < nb; i++) begin
      lv(1'b0, 28);
      lv(1'b1, w[i] ? 84 : 28);
    end
    if (stop) lv(1'b0, 28);
  endtask

  task automatic rep_burst();
    lv(1'b0, 450);
    lv(1'b1, 112);
    lv(1'b0, 28);
  endtask

  initial begin
    int v, r, e, v1, k;
    logic [31:0] w6;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_data", 64'(b0.o_data), 64'h0);
    chk("rst_code", 64'(b0.o_err_code), 64'h0);
    chk("rst_busy", 64'(b0.o_busy), 64'h0);
    chk("rst_valid", 64'(b0.o_valid), 64'h0);
    lv(1'b1, 20);

    // 1: good frame addr 04 cmd 08
    v = nv0;
    send(32'hF708FB04, 32, 1'b1);
    lv(1'b1, 40);
    chk("t1_valid", 64'(nv0 - v), 64'd1);
    chk("t1_data", 64'(b0.o_data), 64'hF708FB04);
    chk("t1_addr", 64'(b0.o_addr), 64'h04);
    chk("t1_cmd", 64'(b0.o_cmd), 64'h08);
    chk("t1_busy", 64'(b0.o_busy), 64'h0);

    // 2: repeat after a frame, then repeat with no frame after reset
    r = nr0;
    rep_burst();
    lv(1'b1, 40);
    chk("t2_rep", 64'(nr0 - r), 64'd1);
    chk("t2_data", 64'(b0.o_data), 64'hF708FB04);
    rst = 1'b1;
    lv(1'b1, 2);
    rst = 1'b0;
    chk("t2_rst_data", 64'(b0.o_data), 64'h0);
    e = ne0; r = nr0;
    rep_burst();
    lv(1'b1, 40);
    chk("t2_err", 64'(ne0 - e), 64'd1);
    chk("t2_code", 64'(b0.o_err_code), 64'd7);
    chk("t2_norep", 64'(nr0 - r), 64'd0);

    // 4: short leader mark, then a good frame
    e = ne0; v = nv0;
    lv(1'b0, 300);
    lv(1'b1, 300);
    chk("t4_err", 64'(ne0 - e), 64'd1);
    chk("t4_code", 64'(b0.o_err_code), 64'd1);
    chk("t4_novalid", 64'(nv0 - v), 64'd0);
    send(32'hF708FB04, 32, 1'b1);
    lv(1'b1, 40);
    chk("t4_valid", 64'(nv0 - v), 64'd1);
    chk("t4_data", 64'(b0.o_data), 64'hF708FB04);

    // 3: byte 3 not the inverse of the command
    e = ne0; v = nv0; v1 = nv1;
    send(32'hF608FB04, 32, 1'b1);
    lv(1'b1, 40);
    chk("t3_err", 64'(ne0 - e), 64'd1);
    chk("t3_code", 64'(b0.o_err_code), 64'd6);
    chk("t3_novalid", 64'(nv0 - v), 64'd0);
    chk("t3_data", 64'(b0.o_data), 64'hF708FB04);
    chk("t3_nochk_valid", 64'(nv1 - v1), 64'd1);
    chk("t3_nochk_data", 64'(b1.o_data), 64'hF608FB04);

    // 5: 20 bits then idle line -> space timeout 600 ticks after the last mark
    e = ne0;
    send(32'h0, 20, 1'b1);
    rxb = 1'b1;
    k = 0;
    for (int i = 1; i <= 900; i++) begin
      @(negedge clk);
      if (b0.o_err) begin k = i; break; end
    end
    chk("t5_fired", 64'(k != 0), 64'd1);
    chk("t5_latency_win", 64'((k >= 600) && (k <= 606)), 64'd1);
    chk("t5_code", 64'(b0.o_err_code), 64'd5);
    lv(1'b1, 2);
    chk("t5_busy", 64'(b0.o_busy), 64'h0);
    chk("t5_err_cnt", 64'(ne0 - e), 64'd1);

    // 6: reset during bit 15, then frame addr 10 cmd 55
    w6 = 32'hAA55EF10;
    e = ne0; v = nv0;
    lv(1'b0, 450);
    lv(1'b1, 225);
    for (int i = 0; i < 14; i++) begin
      lv(1'b0, 28);
      lv(1'b1, w6[i] ? 84 : 28);
    end
    lv(1'b0, 28);
    lv(1'b1, 10);
    rst = 1'b1;
    lv(1'b1, 3);
    rst = 1'b0;
    lv(1'b1, 700);
    chk("t6_noerr", 64'(ne0 - e), 64'd0);
    chk("t6_busy", 64'(b0.o_busy), 64'h0);
    send(w6, 32, 1'b1);
    lv(1'b1, 40);
    chk("t6_valid", 64'(nv0 - v), 64'd1);
    chk("t6_data", 64'(b0.o_data), 64'hAA55EF10);
    chk("t6_addr", 64'(b0.o_addr), 64'h10);
    chk("t6_cmd", 64'(b0.o_cmd), 64'h55);

    chk("pulse_excl", 64'(nmulti), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
